// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART serialiser. Latches a byte on tx_start and shifts it out LSB-first on txd.
// Define UART_TX_PARITY_EN to insert an even-parity cell after bit 7 (11-cell frame).
module uart_tx #(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned BAUD_RATE    = 115_200,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] data_in,
   output logic       txd,
   output logic       tx_done
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_nxt;
   logic [2:0]      r_bit_idx;
   logic [2:0]      w_bit_idx_nxt;
   logic [2:0]      w_bit_inc;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic            r_txd;
   logic            w_txd_nxt;
   logic            r_tx_done;
   logic            w_tx_done_nxt;
   logic            w_cell_end;

   assign w_cell_end = (r_cnt == CntMax);
   assign w_bit_inc  = r_bit_idx + 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
         r_tx_done <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_txd     <= w_txd_nxt;
         r_tx_done <= w_tx_done_nxt;
      end
   end

   // txd is computed one cycle ahead so the line changes exactly on the cell boundary edge.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = w_cell_end ? '0 : r_cnt + CntW'(1);
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_txd_nxt     = r_txd;
      w_tx_done_nxt = 1'b0;
      case (r_state)
         StIdle: begin
            w_cnt_nxt = '0;
            w_txd_nxt = 1'b1;
            if (tx_start) begin
               w_shift_nxt = data_in;
               w_state_nxt = StStart;
               w_txd_nxt   = 1'b0;
            end
         end
         StStart: begin
            if (w_cell_end) begin
               w_state_nxt   = StData;
               w_bit_idx_nxt = 3'd0;
               w_txd_nxt     = r_shift[0];
            end
         end
         StData: begin
            if (w_cell_end) begin
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = StParity;
                  w_txd_nxt   = ^r_shift;
`else
                  w_state_nxt = StStop;
                  w_txd_nxt   = 1'b1;
`endif
               end else begin
                  w_bit_idx_nxt = w_bit_inc;
                  w_txd_nxt     = r_shift[w_bit_inc];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (w_cell_end) begin
               w_state_nxt = StStop;
               w_txd_nxt   = 1'b1;
            end
         end
`endif
         StStop: begin
            if (w_cell_end) begin
               w_state_nxt   = StIdle;
               w_bit_idx_nxt = 3'd0;
               w_txd_nxt     = 1'b1;
               w_tx_done_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

   assign txd     = r_txd;
   assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx; compares the line, cell by cell, against the
// frame a byte should produce. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

   localparam int CPB = 50_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
   localparam int NCELL = 11;
`else
   localparam int NCELL = 10;
`endif
   localparam int FRAME = NCELL * CPB;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] data_in  = 8'h00;
   logic       txd;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   uart_tx dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start),
      .data_in  (data_in),
      .txd      (txd),
      .tx_done  (tx_done)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level in frame cell c for byte b: start, data LSB-first, [parity], stop.
   function automatic logic cell_val(input logic [7:0] b, input int c);
      int ones;
      if (c == 0) return 1'b0;
      if (c <= 8) return b[c-1];
      if (NCELL == 11 && c == 9) begin
         ones = 0;
         for (int k = 0; k < 8; k++) ones += int'(b[k]);
         return logic'(ones % 2);
      end
      return 1'b1;
   endfunction

   // Caller has already driven tx_start=1 and data_in=b at the current negedge.
   task automatic send(input string name, input logic [7:0] b, input bit noisy, input int hold,
                       input int chg_at, input logic [7:0] chg_val,
                       input logic nxt_start, input logic [7:0] nxt_data);
      int bad[NCELL];
      int early;
      early = 0;
      foreach (bad[c]) bad[c] = 0;
      @(posedge clk);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (txd !== cell_val(b, i / CPB)) bad[i / CPB]++;
         if (tx_done !== 1'b0) early++;
         if (noisy) begin
            tx_start = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
         end else begin
            if (i + 1 == hold) tx_start = 1'b0;
            if (i == chg_at) data_in = chg_val;
         end
      end
      foreach (bad[c]) chk($sformatf("%s cell%0d bad clocks", name, c), bad[c], 0);
      chk({name, " tx_done early"}, early, 0);
      @(negedge clk);
      chk({name, " tx_done pulse"}, {31'd0, tx_done}, 1);
      chk({name, " txd after stop"}, {31'd0, txd}, 1);
      tx_start = nxt_start;
      data_in  = nxt_data;
   endtask

   task automatic idle(input string name, input int n);
      int bad_line;
      int bad_done;
      bad_line = 0;
      bad_done = 0;
      repeat (n) begin
         @(negedge clk);
         if (txd !== 1'b1) bad_line++;
         if (tx_done !== 1'b0) bad_done++;
      end
      chk({name, " line not idle"}, bad_line, 0);
      chk({name, " stray tx_done"}, bad_done, 0);
   endtask

   initial begin
      logic [7:0] rb;

      // Reset held low ~11 ns across the first rising edge.
      #1 reset = 1'b0;
      #5;
      chk("reset txd", {31'd0, txd}, 1);
      chk("reset tx_done", {31'd0, tx_done}, 0);
      #6;
      chk("reset txd held", {31'd0, txd}, 1);
      reset = 1'b1;
      idle("post-reset", 20);

      tx_start = 1'bx;
      idle("x start", 5);
      tx_start = 1'b0;

      tx_start = 1'b1;
      data_in  = 8'hAA;
      send("AA", 8'hAA, 1'b0, 1, -1, 8'h00, 1'b0, 8'h00);
      idle("AA idle", 10);

      tx_start = 1'b1;
      data_in  = 8'hC3;
      send("long start", 8'hC3, 1'b0, 250, -1, 8'h00, 1'b0, 8'h00);
      idle("long idle", 10);

      tx_start = 1'b1;
      data_in  = 8'h55;
      send("data change", 8'h55, 1'b0, 1, 3 * CPB + 100, 8'hFF, 1'b0, 8'h00);
      idle("change idle", 10);

      tx_start = 1'b1;
      data_in  = 8'h0F;
      send("b2b first", 8'h0F, 1'b0, FRAME + 10, -1, 8'h00, 1'b1, 8'hF0);
      send("b2b second", 8'hF0, 1'b0, 1, -1, 8'h00, 1'b0, 8'h00);
      idle("b2b idle", 10);

      // Reset in the middle of bit 4 of an 8'hAA frame.
      tx_start = 1'b1;
      data_in  = 8'hAA;
      @(posedge clk);
      @(negedge clk);
      tx_start = 1'b0;
      repeat (5 * CPB + 199) @(negedge clk);
      chk("pre-reset bit4", {31'd0, txd}, 0);
      #3 reset = 1'b0;
      #1;
      chk("mid reset txd", {31'd0, txd}, 1);
      chk("mid reset tx_done", {31'd0, tx_done}, 0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      idle("after mid reset", FRAME);

      tx_start = 1'b1;
      data_in  = 8'h07;
      send("clean 07", 8'h07, 1'b0, 1, -1, 8'h00, 1'b0, 8'h00);
      idle("07 idle", 10);

      for (int f = 0; f < 3; f++) begin
         rb       = 8'($urandom);
         tx_start = 1'b1;
         data_in  = rb;
         send($sformatf("rand%0d", f), rb, 1'b1, 1, -1, 8'h00, 1'b0, 8'h00);
         idle($sformatf("rand%0d idle", f), 5);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
